// File: rtl/sum_pipe_alu.sv
// -----------------------------------------------------------------------------
// sum_pipe_alu
//
// Pipelined WIDTH-bit adder/subtractor. The add is split into STAGES equal
// chunks of CHUNK = WIDTH/STAGES bits; stage k adds chunk k and registers the
// chunk carry for stage k+1. Operands not yet consumed travel forward with the
// partial result, so each beat is fully self-contained in its stage register.
// Subtraction is A + ~B + 1, with sub feeding the stage-0 carry-in.
//
// WIDTH must be an exact multiple of STAGES.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every valid and data register
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle (= advance)
//   a, b       operands
//   sub        0: a+b, 1: a-b
//   out_valid  result beat available
//   out_ready  consumer takes the result
//   result     sum/difference modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       result == 0
//
// Flow control is a global stall: the whole pipeline moves when the output
// slot is empty or being drained, otherwise every stage holds. Bubbles move
// through as valid=0 entries and are never collapsed.
// -----------------------------------------------------------------------------
module sum_pipe_alu #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // One in-flight beat. res holds the chunks already summed; opa/opb hold the
  // operands (B already inverted for subtract), whose upper chunks are still
  // to be consumed by later stages. Their MSBs are the sign bits the final
  // stage needs for overflow.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
  } beat_t;

  beat_t stage_q [STAGES];
  beat_t stage_d [STAGES];
  beat_t in_beat;

  // The final stage also registers the flags that need the complete result.
  logic  ovf_q, ovf_d;
  logic  zero_q, zero_d;

  logic  advance;

  // Adds chunk k of the beat's operands plus its incoming carry, writes the
  // chunk into the partial result and replaces the carry with the chunk
  // carry-out. Everything else passes through unchanged.
  function automatic beat_t add_chunk(input beat_t beat, input int k);
    beat_t      nxt;
    logic [CHUNK:0] sum;
    nxt = beat;
    sum = {1'b0, beat.opa[k*CHUNK +: CHUNK]}
        + {1'b0, beat.opb[k*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, beat.carry};
    nxt.res[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    nxt.carry                 = sum[CHUNK];
    return nxt;
  endfunction

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // NOTE: every signal driven from always_comb receives a value on every pass
  // (defaults first), so no storage is implied and no latch is inferred.
  always_comb begin
    in_beat       = '0;
    in_beat.valid = in_valid;
    in_beat.carry = sub;
    in_beat.opa   = a;
    in_beat.opb   = sub ? ~b : b;

    stage_d[0] = add_chunk(in_beat, 0);
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = add_chunk(stage_q[k-1], k);
    end

    // Same operand signs but a result of the other sign means the signed
    // sum did not fit.
    ovf_d  = (stage_d[LAST].opa[WIDTH-1] == stage_d[LAST].opb[WIDTH-1]) &&
             (stage_d[LAST].res[WIDTH-1] != stage_d[LAST].opa[WIDTH-1]);
    zero_d = (stage_d[LAST].res == '0);
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // that every stage samples its predecessor's value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are cleared along with the valid bits so every
      // output reads 0 right after reset, not just out_valid.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = stage_q[LAST].valid;
  assign result    = stage_q[LAST].res;
  assign cout      = stage_q[LAST].carry;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sum_pipe_alu.sv
// -----------------------------------------------------------------------------
// tb_sum_pipe_alu
//
// Four instances share one stimulus bus (operands truncated per instance):
//   sel 0: WIDTH=32 STAGES=4   sel 1: WIDTH=8 STAGES=1
//   sel 2: WIDTH=8  STAGES=8   sel 3: WIDTH=64 STAGES=4
// Only the selected instance is checked. A negedge monitor keeps an in-order
// scoreboard of expected results computed with plain arithmetic; each entry
// counts the advancing edges it has seen so the output timing is checked too.
// -----------------------------------------------------------------------------
module tb_sum_pipe_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic [3:0]  ir, ov, co, vf, zf;
  logic [31:0] r32;
  logic [7:0]  r8a, r8b;
  logic [63:0] r64;

  int          sel = 0;
  logic        cur_ir, cur_ov, cur_co, cur_vf, cur_zf;
  logic [63:0] cur_res;
  int          cur_w, cur_s;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  always #5 clk = ~clk;

  sum_pipe_alu #(.WIDTH(32), .STAGES(4)) u_w32s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a[31:0]), .b(b[31:0]), .sub(sub), .out_valid(ov[0]),
    .out_ready(out_ready), .result(r32), .cout(co[0]), .overflow(vf[0]),
    .zero(zf[0]));

  sum_pipe_alu #(.WIDTH(8), .STAGES(1)) u_w8s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov[1]),
    .out_ready(out_ready), .result(r8a), .cout(co[1]), .overflow(vf[1]),
    .zero(zf[1]));

  sum_pipe_alu #(.WIDTH(8), .STAGES(8)) u_w8s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ov[2]),
    .out_ready(out_ready), .result(r8b), .cout(co[2]), .overflow(vf[2]),
    .zero(zf[2]));

  sum_pipe_alu #(.WIDTH(64), .STAGES(4)) u_w64s4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[3]),
    .a(a), .b(b), .sub(sub), .out_valid(ov[3]),
    .out_ready(out_ready), .result(r64), .cout(co[3]), .overflow(vf[3]),
    .zero(zf[3]));

  always_comb begin
    cur_ir = ir[sel[1:0]];
    cur_ov = ov[sel[1:0]];
    cur_co = co[sel[1:0]];
    cur_vf = vf[sel[1:0]];
    cur_zf = zf[sel[1:0]];
    case (sel)
      0:       begin cur_res = {32'b0, r32}; cur_w = 32; cur_s = 4; end
      1:       begin cur_res = {56'b0, r8a}; cur_w = 8;  cur_s = 1; end
      2:       begin cur_res = {56'b0, r8b}; cur_w = 8;  cur_s = 8; end
      default: begin cur_res = r64;          cur_w = 64; cur_s = 4; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          age;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unsigned and signed meaning of the operation, straight from arithmetic:
  // carry = unsigned sum overflowed / no borrow, overflow = signed result out
  // of range (judged from the original operand signs).
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic sv, input int w);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] aa, bb;
    logic [64:0] s65;
    logic        sa, sb, sr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & mask;
    bb   = bv & mask;
    if (!sv) begin
      s65   = {1'b0, aa} + {1'b0, bb};
      e.res = s65[63:0] & mask;
      e.c   = s65[w];
    end else begin
      e.res = (aa - bb) & mask;
      e.c   = (aa >= bb);
    end
    sa    = aa[w-1];
    sb    = bb[w-1];
    sr    = e.res[w-1];
    e.v   = sv ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    e.z   = (e.res == 64'd0);
    e.age = 0;
    return e;
  endfunction

  exp_t mon_e;
  logic mon_due;
  logic mon_adv;

  // Samples at negedge: everything seen here describes the coming posedge.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else begin
      mon_due = (sbq.size() > 0) && (sbq[0].age == cur_s);
      check("out_valid_timing", {63'b0, cur_ov}, {63'b0, mon_due});
      mon_adv = !cur_ov || out_ready;
      check("in_ready_rule", {63'b0, cur_ir}, {63'b0, mon_adv});
      if (cur_ov && out_ready && sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        check("sb_result",   cur_res, mon_e.res);
        check("sb_cout",     {63'b0, cur_co}, {63'b0, mon_e.c});
        check("sb_overflow", {63'b0, cur_vf}, {63'b0, mon_e.v});
        check("sb_zero",     {63'b0, cur_zf}, {63'b0, mon_e.z});
        n_pop++;
      end
      if (mon_adv) begin
        foreach (sbq[i]) sbq[i].age++;
      end
      if (in_valid && cur_ir) begin
        mon_e     = model(a, b, sub, cur_w);
        mon_e.age = 1;
        sbq.push_back(mon_e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      4:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic new_data();
    a   = pick(cur_w);
    b   = pick(cur_w);
    sub = 1'($urandom_range(0, 1));
  endtask

  // Offers one beat into an empty pipeline and counts edges (acceptance edge
  // included) until out_valid shows.
  task automatic send_and_wait(input logic [63:0] av, input logic [63:0] bv,
                               input logic sv, output int lat);
    a         = av;
    b         = bv;
    sub       = sv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("accept_ready", {63'b0, cur_ir}, 64'd1);
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!cur_ov && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = 0;
    while (sbq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(sbq.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors for the 32-bit, 4-stage instance
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int start;
    int sent;
    int cyc;
    int acc_cnt;
    logic acc;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    // Reset state
    sel   = 0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_out_valid", {63'b0, cur_ov}, 64'd0);
    check("rst_result",    cur_res, 64'd0);
    check("rst_cout",      {63'b0, cur_co}, 64'd0);
    check("rst_overflow",  {63'b0, cur_vf}, 64'd0);
    check("rst_zero",      {63'b0, cur_zf}, 64'd0);
    check("rst_in_ready",  {63'b0, cur_ir}, 64'd1);
    reset = 1'b0;
    tick();

    // Table-driven single beats: value, flags and exact latency
    for (int i = 0; i < 7; i++) begin
      send_and_wait({32'b0, vecs[i].a}, {32'b0, vecs[i].b}, vecs[i].sub, lat);
      check("vec_latency",  64'(lat), 64'd4);
      check("vec_result",   cur_res, {32'b0, vecs[i].res});
      check("vec_cout",     {63'b0, cur_co}, {63'b0, vecs[i].c});
      check("vec_overflow", {63'b0, cur_vf}, {63'b0, vecs[i].v});
      check("vec_zero",     {63'b0, cur_zf}, {63'b0, vecs[i].z});
      tick();
    end

    // Back-to-back stream of 8 beats with a 3-cycle consumer stall
    start = n_pop;
    sent  = 0;
    cyc   = 0;
    new_data();
    while (sent < 8 && cyc < 60) begin
      in_valid  = 1'b1;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        check("stall_in_ready", {63'b0, cur_ir}, 64'd0);
      end
      acc = cur_ir;
      tick();
      if (acc) begin
        sent++;
        new_data();
      end
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'd8);
    drain("stream_drain");
    check("stream_count", 64'(n_pop - start), 64'd8);

    // Reset with three beats in flight; reset also beats in_valid/out_ready
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_data();
      in_valid = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("flush_out_valid", {63'b0, cur_ov}, 64'd0);
    check("flush_result",    cur_res, 64'd0);
    check("flush_cout",      {63'b0, cur_co}, 64'd0);
    check("flush_overflow",  {63'b0, cur_vf}, 64'd0);
    check("flush_zero",      {63'b0, cur_zf}, 64'd0);
    check("flush_in_ready",  {63'b0, cur_ir}, 64'd1);
    send_and_wait(64'h1234_5678, 64'h1111_1111, 1'b0, lat);
    check("post_flush_latency", 64'(lat), 64'd4);
    check("post_flush_result",  cur_res, 64'h2345_6789);
    tick();

    // Randomised sweep over the other parameter sets
    for (int s = 1; s <= 3; s++) begin
      sel      = s;
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset   = 1'b0;
      start   = n_pop;
      acc_cnt = 0;
      cyc     = 0;
      new_data();
      while (acc_cnt < 1000 && cyc < 20000) begin
        if (!in_valid) in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_valid && cur_ir;
        tick();
        if (acc) begin
          acc_cnt++;
          in_valid = 1'b0;
          new_data();
        end
        cyc++;
      end
      check("sweep_accepted", 64'(acc_cnt), 64'd1000);
      drain("sweep_drain");
      check("sweep_count", 64'(n_pop - start), 64'd1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
